// File: rtl/neuro_pkg.sv
// Shared types and constants for the neuro matrix datapath.
package neuro_pkg;

  localparam int NEURO_DATA_W = 32;

  localparam logic [1:0] MODE_ACC   = 2'b00;
  localparam logic [1:0] MODE_STORE = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  localparam logic [1:0] MODE_NOP   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR, S_FIN} acc_state_t;

  // Command header captured on accept; the block payload is held separately
  // because its width depends on the instance parameters.
  typedef struct packed {
    logic [1:0] mode;
    logic [9:0] row;
    logic [9:0] col;
  } cmd_hdr_t;

endpackage

// File: rtl/block_addr_gen.sv
// Maps (block origin, beat, lane) to a buffer word address and in-bounds flag.
module block_addr_gen #(
  parameter int BLK_K = 4,
  parameter int LANES = 4,
  parameter int MAT_M = 16,
  parameter int MAT_N = 16,
  parameter int BW    = 4,
  parameter int LW    = 2,
  parameter int AW    = 8
) (
  input  logic [9:0]    row,
  input  logic [9:0]    col,
  input  logic [BW-1:0] beat,
  input  logic [LW-1:0] lane,
  output logic [AW-1:0] addr,
  output logic          inb
);

  int          e;
  logic [10:0] r, c;

  // Target coordinates are 11 bits so origin + offset never wraps into range.
  always_comb begin
    e    = int'(beat) * LANES + int'(lane);
    r    = {1'b0, row} + 11'(e / BLK_K);
    c    = {1'b0, col} + 11'(e % BLK_K);
    inb  = (int'(r) < MAT_M) && (int'(c) < MAT_N);
    addr = AW'(int'(r) * MAT_N + int'(c));
  end

endmodule

// File: rtl/fadd.sv
// Combinational IEEE-754 single adder: truncating, denormals flushed to zero,
// overflow saturates to infinity, inf/NaN operands pass through.
module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        big_a, found;
  logic [31:0] x, z;
  logic [7:0]  d;
  logic [26:0] mx, mz;
  logic [27:0] s, sn;
  logic [8:0]  e;
  logic [4:0]  lz;

  // Align the smaller operand, add/subtract, then renormalise.
  always_comb begin
    big_a = a[30:0] >= b[30:0];
    x     = big_a ? a : b;
    z     = big_a ? b : a;
    d     = x[30:23] - z[30:23];
    mx    = {1'b1, x[22:0], 3'b000};
    mz    = (z[30:23] == 8'd0 || d > 8'd26) ? 27'd0 : ({1'b1, z[22:0], 3'b000} >> d);
    s     = (x[31] == z[31]) ? ({1'b0, mx} + {1'b0, mz}) : ({1'b0, mx} - {1'b0, mz});
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--)
      if (!found && s[i]) begin
        found = 1'b1;
        lz    = 5'(26 - i);
      end
    sn = s << lz;
    e  = {1'b0, x[30:23]};
    y  = '0;
    if (x[30:23] == 8'hFF)
      y = x;
    else if (x[30:23] == 8'd0)
      y = '0;
    else if (s[27]) begin
      e = e + 9'd1;
      y = (e >= 9'd255) ? {x[31], 8'hFF, 23'd0} : {x[31], e[7:0], s[26:4]};
    end else if (s == 28'd0 || e <= {4'd0, lz})
      y = '0;
    else begin
      e = e - {4'd0, lz};
      y = {x[31], e[7:0], sn[25:3]};
    end
  end

endmodule

// File: rtl/block_accumulate.sv
// Result buffer owner: accumulates/stores one product block per command or
// clears the buffer, LANES elements per cycle.
module block_accumulate
  import neuro_pkg::*;
#(
  parameter int DATA_W = NEURO_DATA_W,
  parameter int BLK_J  = 4,
  parameter int BLK_K  = 4,
  parameter int MAT_M  = 16,
  parameter int MAT_N  = 16,
  parameter int LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_mode,
  input  logic [9:0]                      cmd_row,
  input  logic [9:0]                      cmd_col,
  input  logic [BLK_J*BLK_K*DATA_W-1:0]   cmd_block,
  output logic                            busy,
  output logic                            done,
  output logic                            oob,
  input  logic                            rd_en,
  input  logic [$clog2(MAT_M*MAT_N)-1:0]  rd_addr,
  output logic [DATA_W-1:0]               rd_data
);

  localparam int NEL       = BLK_J * BLK_K;
  localparam int NW        = MAT_M * MAT_N;
  localparam int AW        = $clog2(NW);
  localparam int RUN_BEATS = NEL / LANES;
  localparam int CLR_BEATS = NW / LANES;
  localparam int MAXB      = (CLR_BEATS > RUN_BEATS) ? CLR_BEATS : RUN_BEATS;
  localparam int BW        = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;

  if ((NEL % LANES) != 0 || (NW % LANES) != 0 || DATA_W != 32) begin : g_param_chk
    $error("block_accumulate: LANES must divide BLK_J*BLK_K and MAT_M*MAT_N; DATA_W must be 32");
  end

  acc_state_t                         state, state_nx;
  cmd_hdr_t                           hdr;
  logic [NEL-1:0][DATA_W-1:0]         blk_q;
  logic [BW-1:0]                      beat;
  logic                               oob_acc, accept;
  logic [NW-1:0][DATA_W-1:0]          mem;

  logic [LANES-1:0][AW-1:0]           addr, wa;
  logic [LANES-1:0]                   inb, we;
  logic [LANES-1:0][DATA_W-1:0]       opb, sum, wd;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == S_FIN);
  assign oob       = done && oob_acc;

  // Per-lane address generation and adder.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    block_addr_gen #(
      .BLK_K(BLK_K), .LANES(LANES), .MAT_M(MAT_M), .MAT_N(MAT_N),
      .BW(BW), .LW(LW), .AW(AW)
    ) u_ag (
      .row (hdr.row),
      .col (hdr.col),
      .beat(beat),
      .lane(LW'(l)),
      .addr(addr[l]),
      .inb (inb[l])
    );
    // Modulo keeps the element index legal while beat runs past the block in CLR.
    assign opb[l] = blk_q[(int'(beat) * LANES + l) % NEL];
    fadd u_fadd (.a(mem[addr[l]]), .b(opb[l]), .y(sum[l]));
  end

  // Next-state: accept from IDLE, count beats in RUN/CLR, one FIN cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (cmd_valid)
          case (cmd_mode)
            MODE_ACC, MODE_STORE: state_nx = S_RUN;
            MODE_CLEAR:           state_nx = S_CLR;
            default:              state_nx = S_FIN;
          endcase
      S_RUN: if (beat == BW'(RUN_BEATS - 1)) state_nx = S_FIN;
      S_CLR: if (beat == BW'(CLR_BEATS - 1)) state_nx = S_FIN;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state, command capture, beat counter and out-of-bounds flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hdr     <= '0;
      blk_q   <= '0;
      beat    <= '0;
      oob_acc <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        hdr     <= '{mode: cmd_mode, row: cmd_row, col: cmd_col};
        blk_q   <= cmd_block;
        beat    <= '0;
        oob_acc <= 1'b0;
      end else if (state == S_RUN || state == S_CLR) begin
        beat <= beat + 1'b1;
        if (state == S_RUN) oob_acc <= oob_acc | ~(&inb);
      end
    end
  end

  // Per-lane write port selection: block element/sum in RUN, zero sweep in CLR.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      we[l] = 1'b0;
      wa[l] = addr[l];
      wd[l] = (hdr.mode == MODE_ACC) ? sum[l] : opb[l];
      if (state == S_RUN)
        we[l] = inb[l];
      else if (state == S_CLR) begin
        we[l] = 1'b1;
        wa[l] = AW'(int'(beat) * LANES + l);
        wd[l] = '0;
      end
    end
  end

  // Result buffer: LANES write ports, lanes never collide within a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else
      for (int l = 0; l < LANES; l++)
        if (we[l]) mem[wa[l]] <= wd[l];
  end

  // Registered read port; sees the buffer before this cycle's writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_block_accumulate.sv
// Directed bench for block_accumulate with hand-computed float results.
module tb_block_accumulate;

  localparam int NEL = 16;
  localparam int NW  = 256;
  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] FIVE  = 32'h40A00000;

  logic                clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rd_en = 1'b0;
  logic [1:0]          cmd_mode = 2'b11;
  logic [9:0]          cmd_row = '0, cmd_col = '0;
  logic [NEL*32-1:0]   cmd_block = '0;
  logic [7:0]          rd_addr = '0;
  logic                cmd_ready, busy, done, oob;
  logic [31:0]         rd_data;
  logic [31:0]         exp_mem [NW];
  int                  n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  block_accumulate dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_block(cmd_block),
    .busy(busy), .done(done), .oob(oob), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = 8'(a);
    step();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic check_buf(input string tag);
    int bad = 0;
    logic [31:0] d;
    for (int i = 0; i < NW; i++) begin
      rd(i, d);
      if (d !== exp_mem[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic set_blk(input int r, input int c, input logic [31:0] v);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        if (r + j < 16 && c + k < 16) exp_mem[(r + j) * 16 + c + k] = v;
  endtask

  // Presents one command for the accept cycle, then scrambles the fields.
  task automatic start_cmd(input logic [1:0] m, input int r, input int c, input logic [NEL*32-1:0] b);
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_mode = m; cmd_row = 10'(r); cmd_col = 10'(c); cmd_block = b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_mode = 2'b11; cmd_row = 10'h3FF; cmd_col = 10'h3FF; cmd_block = '1;
  endtask

  // Counts cycles from accept (cycle 1 = first after accept) up to done.
  task automatic wait_done(input int lat0, output int lat, output logic o, output int nbusy, output int nrdy);
    lat = lat0; nbusy = 0; nrdy = 0; o = 1'b0;
    while (!done && lat < 300) begin
      if (busy) nbusy++;
      if (cmd_ready) nrdy++;
      step();
      lat++;
    end
    if (busy) nbusy++;
    if (cmd_ready) nrdy++;
    check("done_seen", done, 1'b1);
    o = oob;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nb, nr;
    logic o;
    logic [31:0] d;
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;

    // Reset
    step(); step();
    check("rst_busy_low", busy, 1'b0);
    check("rst_done_low", done, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_oob", oob, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check_buf("rst_buf_zero");

    // STORE then ACC of ones at (0,0)
    start_cmd(2'b01, 0, 0, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    check("store_lat", lat, 5);
    check("store_oob", o, 1'b0);
    start_cmd(2'b00, 0, 0, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    check("acc_lat", lat, 5);
    check("acc_oob", o, 1'b0);
    set_blk(0, 0, TWO);
    rd(0, d);  check("acc_a0", d, TWO);
    rd_addr = 8'd5; step();
    check("rd_hold", rd_data, TWO);
    rd(19, d); check("acc_a19", d, TWO);
    rd(51, d); check("acc_a51", d, TWO);
    rd(4, d);  check("acc_a4", d, 32'h0);
    check_buf("acc_buf");

    // ACC at the corner: partially out of bounds
    start_cmd(2'b00, 14, 14, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    check("corner_lat", lat, 5);
    check("corner_oob", o, 1'b1);
    exp_mem[238] = ONE; exp_mem[239] = ONE; exp_mem[254] = ONE; exp_mem[255] = ONE;
    check_buf("corner_buf");
    start_cmd(2'b00, 0, 0, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    check("origin_oob", o, 1'b0);
    set_blk(0, 0, THREE);
    rd(48, d); check("acc3_a48", d, THREE);

    // NOP
    start_cmd(2'b11, 0, 0, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    check("nop_lat", lat, 1);
    check("nop_oob", o, 1'b0);

    // Fill with fives, then CLEAR with cmd_valid held
    for (int r = 0; r < 16; r += 4)
      for (int c = 0; c < 16; c += 4) begin
        start_cmd(2'b01, r, c, {NEL{FIVE}});
        wait_done(1, lat, o, nb, nr);
      end
    for (int i = 0; i < NW; i++) exp_mem[i] = FIVE;
    rd(100, d); check("fill_a100", d, FIVE);
    check_buf("fill_buf");
    cmd_mode = 2'b10; cmd_valid = 1'b1;
    step();
    wait_done(1, lat, o, nb, nr);
    check("clr_lat", lat, 65);
    check("clr_busy_cycles", nb, 65);
    check("clr_not_ready", nr, 0);
    check("clr_oob", o, 1'b0);
    check("clr_ready_after", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    wait_done(1, lat, o, nb, nr);
    check("clr2_lat", lat, 65);
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
    check_buf("clr_buf");

    // Read racing an ACC write at address 0
    start_cmd(2'b01, 0, 0, {NEL{ONE}});
    wait_done(1, lat, o, nb, nr);
    start_cmd(2'b00, 0, 0, {NEL{ONE}});
    rd_en = 1'b1; rd_addr = 8'd0;
    step();
    check("race_old", rd_data, ONE);
    step();
    check("race_new", rd_data, TWO);
    rd_en = 1'b0;
    wait_done(3, lat, o, nb, nr);
    check("race_lat", lat, 5);

    // Reset after beat 2 of an ACC
    start_cmd(2'b00, 0, 0, {NEL{ONE}});
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) nb++;
      step();
    end
    check("abort_no_done", nb, 0);
    rst_n = 1'b1;
    step();
    check("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
    check_buf("abort_buf");
    start_cmd(2'b01, 8, 4, {NEL{THREE}});
    wait_done(1, lat, o, nb, nr);
    check("post_lat", lat, 5);
    check("post_oob", o, 1'b0);
    rd(132, d); check("post_a132", d, THREE);
    rd(183, d); check("post_a183", d, THREE);
    rd(131, d); check("post_a131", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
